// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: sends up to four bytes of a 32-bit word, LSB byte
// first, skipping masked byte slots; bit timing comes from an external tick.
module uart_word_tx #(
  parameter int unsigned BITLENGTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [31:0] data,
  input  logic [3:0]  disabled_groups,
  input  logic        write,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    NEXT,
    SEND
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(BITLENGTH - 1);
  localparam logic [3:0] STOP_BIT  = 4'd9;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [8:0]  frame_q, frame_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [7:0]  cur_byte;

  assign cur_byte = data_q[{byte_idx_q, 3'b000} +: 8];
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    tick_cnt_d = tick_cnt_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (write) begin
          data_d     = data;
          mask_d     = disabled_groups;
          byte_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = NEXT;
        end
      end

      NEXT: begin
        tx_d = 1'b1;
        if (!mask_q[byte_idx_q]) begin
          // start bit goes straight to tx; frame holds the remaining {stop, data}
          frame_d    = {1'b1, cur_byte};
          bit_idx_d  = '0;
          tick_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = SEND;
        end else if (byte_idx_q == 2'd3) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end

      SEND: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (bit_idx_q == STOP_BIT) begin
              tx_d = 1'b1;
              if (byte_idx_q == 2'd3) begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end else begin
                byte_idx_d = byte_idx_q + 2'd1;
                state_d    = NEXT;
              end
            end else begin
              tx_d      = frame_q[0];
              frame_d   = {1'b1, frame_q[8:1]};
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      tick_cnt_q <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      tick_cnt_q <= tick_cnt_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: stimulus queues expected bytes, a monitor
// decodes frames on tx and compares them against the queue.
module tb_uart_word_tx;

  localparam int unsigned BL = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick;
  logic [31:0] data;
  logic [3:0]  disabled_groups;
  logic        write;
  logic        tx;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned tick_div = 1;
  logic [7:0]  exp_q[$];

  always #5 clock = ~clock;

  uart_word_tx #(.BITLENGTH(BL)) dut (
    .clock           (clock),
    .reset           (reset),
    .tick            (tick),
    .data            (data),
    .disabled_groups (disabled_groups),
    .write           (write),
    .tx              (tx),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // tick generator: one pulse every tick_div clocks
  initial begin : tick_gen
    int unsigned c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(negedge clock);
      c++;
      tick = ((c % tick_div) == 0);
    end
  end

  // monitor: detects a start bit, samples tx after every tick, checks frame shape and byte
  initial begin : monitor
    logic        prev;
    logic        have_exp;
    logic        bad;
    logic        aborted;
    logic        t;
    logic [7:0]  exp_b;
    logic [9:0]  bits;
    logic [9:0]  seen;
    int unsigned n;
    int unsigned cyc;
    int unsigned idx;
    prev = 1'b1;
    exp_b = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && prev === 1'b1 && tx === 1'b0) begin
        have_exp = (exp_q.size() > 0);
        if (!have_exp) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame required=none");
        end else begin
          exp_b = exp_q.pop_front();
        end
        bits = '0;
        seen = '0;
        bits[0] = tx;
        seen[0] = 1'b1;
        bad = 1'b0;
        aborted = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 10 * BL && cyc < 20000 && !aborted) begin
          @(posedge clock);
          t = tick;
          @(negedge clock);
          cyc++;
          if (reset !== 1'b0) begin
            aborted = 1'b1;
          end else if (t) begin
            n++;
            if (n < 10 * BL) begin
              idx = n / BL;
              if (!seen[idx]) begin
                seen[idx] = 1'b1;
                bits[idx] = tx;
              end else if (bits[idx] !== tx) begin
                bad = 1'b1;
              end
            end else if (tx !== 1'b1) begin
              bad = 1'b1;
            end
          end
        end
        if (!aborted && have_exp) begin
          check("frame_shape", {28'd0, bad, (cyc >= 20000), bits[0], bits[9]}, 32'h1);
          check("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
        end
      end
      prev = (reset === 1'b0) ? tx : 1'b1;
    end
  end

  task automatic do_write(input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    data = d;
    disabled_groups = m;
    write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic measure_busy(output int n, output logic tx_high);
    n = 0;
    tx_high = 1'b1;
    while (busy === 1'b1 && n < 5000) begin
      if (tx !== 1'b1) tx_high = 1'b0;
      n++;
      @(negedge clock);
    end
  endtask

  initial begin : stimulus
    int   n;
    logic txh;
    logic ok;
    reset = 1'b1;
    write = 1'b0;
    data = '0;
    disabled_groups = '0;
    #12;
    check("reset_tx", {31'd0, tx}, 32'h1);
    check("reset_busy", {31'd0, busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // single byte 0x55, other slots masked
    exp_q.push_back(8'h55);
    do_write(32'h0000_0055, 4'b1110);
    check("busy_after_write", {31'd0, busy}, 32'h1);
    check("tx_in_next", {31'd0, tx}, 32'h1);
    measure_busy(n, txh);
    check("busy_len_single", n, 164);
    repeat (5) @(negedge clock);

    // full word, all four bytes
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    do_write(32'hA5C3_0F81, 4'b0000);
    measure_busy(n, txh);
    check("busy_len_word", n, 644);
    check("queue_after_word", exp_q.size(), 0);
    repeat (5) @(negedge clock);

    // everything masked: only NEXT cycles, no frame
    do_write(32'hDEAD_BEEF, 4'b1111);
    measure_busy(n, txh);
    check("busy_len_masked", n, 4);
    check("tx_high_masked", {31'd0, txh}, 32'h1);
    repeat (5) @(negedge clock);

    // slow tick, write while busy must be ignored
    tick_div = 4;
    exp_q.push_back(8'h3C);
    do_write(32'h1234_563C, 4'b1110);
    repeat (300) @(negedge clock);
    check("busy_mid_frame", {31'd0, busy}, 32'h1);
    do_write(32'hFFFF_FFFF, 4'b0000);
    measure_busy(n, txh);
    check("slow_idle_reached", {31'd0, (n < 5000)}, 32'h1);
    repeat (10) @(negedge clock);
    check("queue_after_slow", exp_q.size(), 0);
    tick_div = 1;
    repeat (5) @(negedge clock);

    // reset during data bit 3 of byte 1
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h9A);
    do_write(32'h0000_9A11, 4'b1100);
    repeat (228) @(negedge clock);
    check("busy_before_abort", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'h1);
    check("abort_busy", {31'd0, busy}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    ok = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("quiet_after_abort", {31'd0, ok}, 32'h1);
    exp_q.push_back(8'hE7);
    do_write(32'h0000_00E7, 4'b1110);
    measure_busy(n, txh);
    check("busy_len_after_abort", n, 164);
    repeat (5) @(negedge clock);

    // write held on the cycle busy falls, then one cycle later
    do_write(32'h1111_1111, 4'b1111);
    repeat (3) @(negedge clock);
    data = 32'h0000_0042;
    disabled_groups = 4'b1110;
    write = 1'b1;
    @(negedge clock);
    check("write_on_fall_ignored", {31'd0, busy}, 32'h0);
    @(negedge clock);
    check("write_after_fall_taken", {31'd0, busy}, 32'h1);
    write = 1'b0;
    exp_q.push_back(8'h42);
    measure_busy(n, txh);
    check("busy_len_retry", n, 164);

    repeat (20) @(negedge clock);
    check("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
